ram8x8_bist: RTL and testbench

March C- built-in self-test controller for the 8-word x 8-bit register-file RAM. It is the initiator side of the RAM port: it drives write data, address and write enable, and checks the read data returned by the RAM. The block sits beside the RAM in the macro wrapper and reports pass/fail, an error count and the first failing location to the top level.

---
 rtl/ram8x8_bist_if.sv | 15 +
 rtl/ram8x8_bist.sv | 143 ++++++++++++++
 tb/tb_ram8x8_bist.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram8x8_bist_if.sv
// RAM port bundle between the March C- BIST controller and the register-file RAM.
// master: drives write data, address and write enable; samples read data.
// slave: RAM side; returns read data combinationally from ram_addr.
interface ram8x8_bist_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] ram_d;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  modport master (output ram_d, output ram_addr, output ram_we, input ram_q);
  modport slave  (input ram_d, input ram_addr, input ram_we, output ram_q);
endinterface

// File: rtl/ram8x8_bist.sv
// March C- BIST controller for the 8x8 register-file RAM; one march operation per cycle.
// Ports: clk/rst_n, start (level run request, taken in IDLE), busy/done/pass status,
// err_cnt/fail_addr/fail_elem diagnostics, ram (master side of the RAM port).
module ram8x8_bist #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  ram8x8_bist_if.master     ram
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  state_t      state;
  logic [2:0]  elem;   // current march element 0..5
  logic        phase;  // 0: read slot, 1: write slot of a two-operation element

  logic              is_down;
  logic              two_op;
  logic [ADDR_W-1:0] last_addr;
  logic              rd_mismatch;
  logic              last_op;
  logic [2:0]        nxt_elem;
  logic              nxt_phase;
  logic [ADDR_W-1:0] nxt_addr;
  logic              nxt_we;
  logic              nxt_bg;
  logic              nxt_one_bg;
  logic [ERR_W-1:0]  err_nxt;

  always_comb begin
    is_down   = (elem == 3'd3) || (elem == 3'd4);
    two_op    = (elem != 3'd0) && (elem != 3'd5);
    last_addr = is_down ? '0 : ADDR_MAX;
    // During a read, ram_d carries the expected value, so it doubles as the reference.
    rd_mismatch = !ram.ram_we && (ram.ram_q != ram.ram_d);
    last_op     = (elem == 3'd5) && (ram.ram_addr == ADDR_MAX);
    err_nxt     = (rd_mismatch && (err_cnt != ERR_MAX)) ? err_cnt + 1'b1 : err_cnt;

    nxt_elem  = elem;
    nxt_phase = 1'b0;
    nxt_addr  = ram.ram_addr;
    if (two_op && !phase) begin
      nxt_phase = 1'b1;
    end else if (ram.ram_addr == last_addr) begin
      nxt_elem = elem + 3'd1;
      nxt_addr = ((nxt_elem == 3'd3) || (nxt_elem == 3'd4)) ? ADDR_MAX : '0;
    end else begin
      nxt_addr = is_down ? ram.ram_addr - 1'b1 : ram.ram_addr + 1'b1;
    end

    // Elements 2 and 4 read the all-ones background and write zeros back;
    // elements 1 and 3 do the opposite. Element 0 only writes 0, element 5 only reads 0.
    nxt_one_bg = (nxt_elem == 3'd2) || (nxt_elem == 3'd4);
    if (nxt_elem == 3'd0) begin
      nxt_we = 1'b1;
      nxt_bg = 1'b0;
    end else if (nxt_elem == 3'd5) begin
      nxt_we = 1'b0;
      nxt_bg = 1'b0;
    end else begin
      nxt_we = nxt_phase;
      nxt_bg = nxt_phase ? !nxt_one_bg : nxt_one_bg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      elem         <= 3'd0;
      phase        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_cnt      <= '0;
      fail_addr    <= '0;
      fail_elem    <= 3'd0;
      ram.ram_d    <= '0;
      ram.ram_addr <= '0;
      ram.ram_we   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state        <= RUN;
            busy         <= 1'b1;
            pass         <= 1'b0;
            err_cnt      <= '0;
            fail_addr    <= '0;
            fail_elem    <= 3'd0;
            elem         <= 3'd0;
            phase        <= 1'b0;
            ram.ram_addr <= '0;
            ram.ram_we   <= 1'b1;
            ram.ram_d    <= '0;
          end
        end
        RUN: begin
          err_cnt <= err_nxt;
          // err_cnt never wraps, so zero means no mismatch seen yet in this run.
          if (rd_mismatch && (err_cnt == '0)) begin
            fail_addr <= ram.ram_addr;
            fail_elem <= elem;
          end
          if (last_op) begin
            state        <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            pass         <= (err_nxt == '0);
            ram.ram_we   <= 1'b0;
            ram.ram_d    <= '0;
            ram.ram_addr <= '0;
          end else begin
            elem         <= nxt_elem;
            phase        <= nxt_phase;
            ram.ram_addr <= nxt_addr;
            ram.ram_we   <= nxt_we;
            ram.ram_d    <= {DATA_W{nxt_bg}};
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram8x8_bist.sv
// Bench for ram8x8_bist: RAM model with injectable faults, scoreboard of per-run results.
module tb_ram8x8_bist;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int ERR_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, pass;
  logic [ERR_W-1:0]  err_cnt;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;

  ram8x8_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_bus ();

  ram8x8_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_elem(fail_elem), .ram(ram_bus.master)
  );

  always #5 clk = ~clk;

  // RAM model: fault_mode 1 = bit 3 stuck-at-1 at address 5, 2 = word 0 stuck at 0x00.
  logic [7:0] mem [8];
  int         fault_mode = 0;
  logic [7:0] q_model;
  int         rst_wr = 0;

  always @(posedge clk) if (ram_bus.ram_we) mem[ram_bus.ram_addr] <= ram_bus.ram_d;
  always @(posedge clk) if (!rst_n && ram_bus.ram_we) rst_wr++;

  always_comb begin
    q_model = mem[ram_bus.ram_addr];
    if (fault_mode == 1 && ram_bus.ram_addr == 3'd5) q_model = q_model | 8'h08;
    if (fault_mode == 2 && ram_bus.ram_addr == 3'd0) q_model = 8'h00;
  end
  assign ram_bus.ram_q = q_model;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic             p;
    logic [ERR_W-1:0] e;
    logic [2:0]       a;
    logic [2:0]       el;
  } exp_t;
  exp_t sb[$];

  // Reference March C- operation stream: write flag, address, data/expected.
  logic       ref_we [80];
  logic [2:0] ref_a  [80];
  logic [7:0] ref_d  [80];

  initial begin
    int n = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 8; k++) begin
        logic [2:0] a;
        logic [7:0] rd;
        a  = (e == 3 || e == 4) ? 3'(7 - k) : 3'(k);
        rd = (e == 2 || e == 4) ? 8'hFF : 8'h00;
        if (e == 0) begin
          ref_we[n] = 1'b1; ref_a[n] = a; ref_d[n] = 8'h00; n++;
        end else if (e == 5) begin
          ref_we[n] = 1'b0; ref_a[n] = a; ref_d[n] = 8'h00; n++;
        end else begin
          ref_we[n] = 1'b0; ref_a[n] = a; ref_d[n] = rd; n++;
          ref_we[n] = 1'b1; ref_a[n] = a; ref_d[n] = ~rd; n++;
        end
      end
    end
  end

  // Monitor: checks each busy cycle against the reference stream and pops the scoreboard on done.
  logic b2b = 1'b0;
  int   cyc = 0, op_idx = 0, wr_cnt = 0, seq_err = 0, last_done = 0;
  logic prev_busy = 1'b0, last_done_vld = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!b2b) last_done_vld = 1'b0;
    if (!rst_n) begin
      op_idx = 0; wr_cnt = 0; seq_err = 0; prev_busy = 1'b0;
    end else begin
      if (busy) begin
        if (op_idx < 80) begin
          if (ram_bus.ram_we !== ref_we[op_idx] || ram_bus.ram_addr !== ref_a[op_idx] ||
              ram_bus.ram_d !== ref_d[op_idx]) seq_err++;
        end else seq_err++;
        if (ram_bus.ram_we) wr_cnt++;
        op_idx++;
      end
      if (!busy && prev_busy) begin
        chk("busy_len", op_idx, 80);
        chk("write_cnt", wr_cnt, 40);
        chk("op_sequence_errs", seq_err, 0);
        op_idx = 0; wr_cnt = 0; seq_err = 0;
      end
      if (done) begin
        chk("done_after_busy", {31'd0, prev_busy}, 1);
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("pass", pass, x.p);
          chk("err_cnt", err_cnt, x.e);
          chk("fail_addr", fail_addr, x.a);
          chk("fail_elem", fail_elem, x.el);
        end
        if (b2b && last_done_vld) chk("done_spacing", cyc - last_done, 82);
        last_done = cyc; last_done_vld = b2b;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_done(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++; failures++;
    $display("FAIL %s: no done within 300 cycles, expected done", name);
  endtask

  task automatic run_once(input int mode, input exp_t x, input string name);
    fault_mode = mode;
    sb.push_back(x);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #1;
    chk({name, "_t1_busy"}, busy, 1);
    chk({name, "_t1_addr"}, ram_bus.ram_addr, 0);
    chk({name, "_t1_we"}, ram_bus.ram_we, 1);
    start = 1'b0;
    wait_done(name);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t good, stuck5, word0;
    good   = '{p: 1'b1, e: 4'd0, a: 3'd0, el: 3'd0};
    stuck5 = '{p: 1'b0, e: 4'd3, a: 3'd5, el: 3'd1};
    word0  = '{p: 1'b0, e: 4'd2, a: 3'd0, el: 3'd2};

    // Reset held with start asserted.
    start = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_fail_elem", fail_elem, 0);
    chk("rst_ram_we", ram_bus.ram_we, 0);
    chk("rst_ram_addr", ram_bus.ram_addr, 0);
    chk("rst_ram_d", ram_bus.ram_d, 0);
    chk("rst_writes", rst_wr, 0);
    start = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_once(0, good, "good");
    run_once(1, stuck5, "stuck_bit3_a5");
    run_once(2, word0, "word0_zero");

    // start held high: faulty run then two good runs back-to-back.
    fault_mode = 1;
    sb.push_back(stuck5);
    sb.push_back(good);
    sb.push_back(good);
    b2b = 1'b1;
    @(posedge clk); #2 start = 1'b1;
    wait_done("b2b_run1");
    fault_mode = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) break;
    end
    chk("b2b_restart_busy", busy, 1);
    chk("b2b_err_cleared", err_cnt, 0);
    wait_done("b2b_run2");
    wait_done("b2b_run3");
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("b2b_no_extra_run", busy, 0);
    b2b = 1'b0;

    // Reset pulse during cycle 30 of a run, then a clean run.
    fault_mode = 0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (29) @(posedge clk);
    #2;
    chk("abort_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ram_we", ram_bus.ram_we, 0);
    chk("abort_ram_addr", ram_bus.ram_addr, 0);
    chk("abort_ram_d", ram_bus.ram_d, 0);
    chk("abort_err_cnt", err_cnt, 0);
    @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_once(0, good, "after_abort");

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
